// File: rtl/jt10_adpcma_fetch.sv
// ADPCM-A nibble feeder: walks ROM from the start block to the end block and
// hands one 4-bit code per sample enable to the channel decoder.
module jt10_adpcma_fetch #(
    parameter int unsigned AW = 24
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          keyon,
    input  logic          keyoff,
    input  logic [AW-9:0] start,
    input  logic [AW-9:0] end_blk,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [3:0]    data,
    output logic          data_valid,
    output logic          clr,
    output logic          busy,
    output logic          flag_end,
    output logic          underrun
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_n;
    logic [AW-1:0] rom_addr_n;
    logic [7:0]    cur, cur_n, nxt, nxt_n;
    logic          cur_ok, cur_ok_n, nxt_ok, nxt_ok_n;
    logic          fetch_done, fetch_done_n, hi, hi_n;
    logic          rom_cs_n, data_valid_n, clr_n, busy_n, flag_end_n, underrun_n;
    logic [3:0]    data_n;
    logic [AW-1:0] first_addr, last_addr;

    assign first_addr = {start, 8'h00};
    assign last_addr  = {end_blk, 8'hFF};

    // Next-state: keyoff beats keyon, keyon beats all run-time activity.
    always_comb begin
        state_n      = state;
        rom_addr_n   = rom_addr;
        cur_n        = cur;
        nxt_n        = nxt;
        cur_ok_n     = cur_ok;
        nxt_ok_n     = nxt_ok;
        fetch_done_n = fetch_done;
        hi_n         = hi;
        data_n       = data;
        data_valid_n = 1'b0;
        clr_n        = 1'b0;
        flag_end_n   = flag_end;
        underrun_n   = underrun;
        rom_cs_n     = 1'b0;
        busy_n       = 1'b0;

        if (keyoff) begin
            state_n = IDLE;
        end else if (keyon) begin
            state_n      = RUN;
            rom_addr_n   = first_addr;
            cur_ok_n     = 1'b0;
            nxt_ok_n     = 1'b0;
            fetch_done_n = 1'b0;
            hi_n         = 1'b1;
            flag_end_n   = 1'b0;
            underrun_n   = 1'b0;
            clr_n        = 1'b1;
        end else if (state == RUN) begin
            if (rom_cs && rom_ok) begin
                nxt_n    = rom_data;
                nxt_ok_n = 1'b1;
                if (rom_addr == last_addr) fetch_done_n = 1'b1;
                else                       rom_addr_n   = rom_addr + AW'(1);
            end
            if (!cur_ok && nxt_ok) begin
                cur_n    = nxt;
                cur_ok_n = 1'b1;
                nxt_ok_n = 1'b0;
                hi_n     = 1'b1;
            end
            if (cen) begin
                if (cur_ok) begin
                    data_n       = hi ? cur[7:4] : cur[3:0];
                    data_valid_n = 1'b1;
                    if (hi) hi_n     = 1'b0;
                    else    cur_ok_n = 1'b0;
                end else if (!nxt_ok && fetch_done) begin
                    flag_end_n = 1'b1;
                    state_n    = IDLE;
                end else begin
                    underrun_n = 1'b1;
                end
            end
        end

        // A restart while a request is open drops rom_cs for one cycle first.
        if (keyon && !keyoff) rom_cs_n = !rom_cs;
        else                  rom_cs_n = (state_n == RUN) && !nxt_ok_n && !fetch_done_n;
        busy_n = (state_n == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rom_addr   <= '0;
            rom_cs     <= 1'b0;
            cur        <= '0;
            nxt        <= '0;
            cur_ok     <= 1'b0;
            nxt_ok     <= 1'b0;
            fetch_done <= 1'b0;
            hi         <= 1'b1;
            data       <= '0;
            data_valid <= 1'b0;
            clr        <= 1'b0;
            busy       <= 1'b0;
            flag_end   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            rom_addr   <= rom_addr_n;
            rom_cs     <= rom_cs_n;
            cur        <= cur_n;
            nxt        <= nxt_n;
            cur_ok     <= cur_ok_n;
            nxt_ok     <= nxt_ok_n;
            fetch_done <= fetch_done_n;
            hi         <= hi_n;
            data       <= data_n;
            data_valid <= data_valid_n;
            clr        <= clr_n;
            busy       <= busy_n;
            flag_end   <= flag_end_n;
            underrun   <= underrun_n;
        end
    end

endmodule

// File: doc/jt10_adpcma_fetch.md
Name: jt10_adpcma_fetch

Overview:
- Upstream feeder for the ADPCM-A channel decoder.
- On key-on it walks ADPCM ROM from the start block to the end block, one byte per ROM handshake.
- It splits each byte into nibbles, high nibble first, and presents one 4-bit code per sample enable, together with a decoder-clear pulse, busy and end status.
- A two-byte buffer (current plus prefetch) hides ROM latency from the decoder.

Parameters:
- AW, 24: ROM byte-address width. The start/end registers are AW-8 bits wide, in 256-byte blocks.

Ports:
- rst  in  1  synchronous active-high reset
- clk  in  1  system clock
- cen  in  1  sample enable, one-cycle pulse, consecutive pulses at least 2 clk apart
- keyon  in  1  one-cycle start pulse
- keyoff  in  1  one-cycle stop pulse
- start  in  AW-8  first block; first byte address = {start,8'h00}
- end  in  AW-8  last block; last byte address = {end,8'hFF}
- rom_addr  out  AW  byte address, stable while rom_cs=1
- rom_cs  out  1  ROM read request
- rom_data  in  8  ROM byte, valid when rom_ok=1
- rom_ok  in  1  read acknowledge
- data  out  4  ADPCM code to decoder ({sign,mag[2:0]})
- data_valid  out  1  one-cycle pulse, data is new
- clr  out  1  one-cycle pulse, decoder resets accumulator and step to 0
- busy  out  1  channel playing
- flag_end  out  1  sticky, end address reached
- underrun  out  1  sticky, a cen found no nibble ready

Behaviour:
- Reset: every output is 0, and the state is IDLE. Internal state is cleared: rom_addr=0, cur_ok=0, nxt_ok=0, fetch_done=0, hi=1.
- States are IDLE and RUN. busy=1 exactly in RUN.
- keyon in any state:
  - rom_addr <= {start,8'h00}; cur_ok, nxt_ok and fetch_done cleared; hi=1.
  - flag_end and underrun cleared; clr=1 for 1 cycle; state becomes RUN.
  - Any ROM handshake in flight is abandoned: rom_cs drops for at least 1 cycle before the new request.
- keyoff: state becomes IDLE and rom_cs=0 next cycle. flag_end is not set. keyoff beats a simultaneous keyon.
- Fetch engine, RUN only:
  - rom_cs=1 while nxt_ok=0 and fetch_done=0.
  - rom_ok is honoured only when rom_cs=1; any other rom_ok is ignored.
  - On an honoured rom_ok: nxt <= rom_data, nxt_ok <= 1, rom_cs low next cycle.
  - If rom_addr=={end,8'hFF}, fetch_done <= 1; else rom_addr <= rom_addr+1, wrapping modulo 2^AW.
  - start>end is legal: the address wraps through all-ones to 0 and continues until it equals the end byte.
- Transfer: if cur_ok=0 and nxt_ok=1, then cur <= nxt, cur_ok <= 1, nxt_ok <= 0, hi <= 1 (one clk). No conflict with the ROM latch is possible, because rom_cs=0 while nxt_ok=1.
- Consume, on cen in RUN:
  - If cur_ok=1: data <= hi ? cur[7:4] : cur[3:0], data_valid=1 next cycle. If hi, then hi <= 0; else cur_ok <= 0.
  - If cur_ok=0, nxt_ok=0 and fetch_done=1: flag_end <= 1, state becomes IDLE, no data_valid.
  - Otherwise: underrun <= 1, data_valid stays 0, data holds.
- Consume and transfer in the same cycle use registered flags. A transfer after consuming the low nibble completes the following clk.
- cen, keyoff and rom_ok arriving in IDLE have no effect.
- data holds its last value between pulses and in IDLE.
- Latency:
  - keyon to first rom_cs = 1 clk.
  - rom_ok to cur_ok = 2 clk.
  - cen to data_valid = 1 clk.

Test Plan:
- Reset, then start=16'h0001, end=16'h0001, keyon. Expect: clr pulse, rom_addr=24'h000100. With zero-wait ROM returning byte 0x3C, the first two cen produce data=3 then data=C.
- Play one block of 256 bytes with ROM data = address low byte. Expect 512 data_valid pulses with nibbles 0,0,0,1,…,F,F. The 513th cen sets flag_end=1 and busy=0, and rom_addr ends at 24'h0001FF with no further rom_cs.
- ROM with 5-cycle rom_ok latency, cen every 64 clk. Expect underrun=0 for the whole run and exactly 2 nibbles per byte.
- ROM holding rom_ok low for 200 clk while cen arrives every 8 clk. Expect underrun=1, no data_valid during the stall, and correct nibble order after recovery.
- keyon mid-block at address 24'h000150 while rom_cs=1. Expect rom_cs low for at least 1 cycle, then rom_addr=new {start,8'h00}, clr pulse, flag_end=0, and the stale rom_ok ignored.
- keyoff and keyon in the same cycle: expect IDLE and busy=0. Then start=16'hFFFF, end=16'h0000: expect the address to wrap 24'hFFFFFF→24'h000000, finishing at 24'h0000FF with flag_end=1.
